// File: rtl/sample_delay.sv
// Programmable sample delay line: circular buffer written once per strobe, read back
// 'offset' samples behind the write pointer, with a fill tracker gating dout_valid.
//
// state | meaning
// FILL  | fewer samples stored than the requested delay; dout_valid held low
// RUN   | enough history for the requested delay; dout_valid follows the strobe
module sample_delay #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] fill
);

  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  accept;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign accept  = en & ~clr;
  assign rd_addr = wr_addr_q - offset;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_addr_q] <= din;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    fill_d       = fill_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (clr) begin
      state_d   = S_FILL;
      wr_addr_d = '0;
      fill_d    = '0;
    end else if (en) begin
      wr_addr_d = wr_addr_q + ADDR_ONE;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + ADDR_ONE;
      end
      // Zero delay bypasses the array so the same-cycle sample comes straight out.
      dout_d       = (offset == '0) ? din : mem_q[rd_addr];
      state_d      = (fill_q >= offset) ? S_RUN : S_FILL;
      dout_valid_d = (fill_q >= offset);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FILL;
      wr_addr_q    <= '0;
      fill_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      fill_q       <= fill_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign wr_addr    = wr_addr_q;
  assign fill       = fill_q;

endmodule

// File: tb/tb_sample_delay.sv
// Self-checking bench for sample_delay: directed scenarios plus a randomized run
// compared against a sample-history model.
module tb_sample_delay;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [7:0] din = '0;
  logic [8:0] offset = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [8:0] wr_addr;
  logic [8:0] fill;

  int checks = 0;
  int failures = 0;

  sample_delay #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .din(din), .offset(offset),
    .dout(dout), .dout_valid(dout_valid), .wr_addr(wr_addr), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic step(input logic e, input logic c, input logic [7:0] d, input logic [8:0] o);
    en = e; clr = c; din = d; offset = o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%0h exp=0", dout); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", dout_valid); end
    checks++; if (wr_addr !== 9'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (fill !== 9'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    rst = 1'b1;
  endtask

  task automatic test_offset3();
    step(1'b0, 1'b1, 8'h00, 9'd3);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 8'(i), 9'd3);
      checks++;
      if (dout_valid !== 1'(i >= 4)) begin failures++; $display("FAIL off3_valid i=%0d got=%0b exp=%0b", i, dout_valid, i >= 4); end
      if (i >= 4) begin
        checks++;
        if (dout !== 8'(i - 3)) begin failures++; $display("FAIL off3_dout i=%0d got=%0d exp=%0d", i, dout, i - 3); end
      end
      checks++;
      if (wr_addr !== 9'(i)) begin failures++; $display("FAIL off3_wr_addr i=%0d got=%0d exp=%0d", i, wr_addr, i); end
    end
  endtask

  task automatic test_offset0();
    step(1'b0, 1'b1, 8'h00, 9'd0);
    step(1'b1, 1'b0, 8'h5A, 9'd0);
    checks++; if (dout !== 8'h5A) begin failures++; $display("FAIL off0_dout got=%0h exp=5a", dout); end
    checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL off0_valid got=%0b exp=1", dout_valid); end
    step(1'b1, 1'b0, 8'hC3, 9'd0);
    checks++; if (dout !== 8'hC3) begin failures++; $display("FAIL off0_dout2 got=%0h exp=c3", dout); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 8'h00, 9'd2);
    for (int n = 0; n < 600; n++) begin
      step(1'b1, 1'b0, 8'(n), 9'd2);
      checks++;
      if (dout_valid !== 1'(n >= 2)) begin failures++; $display("FAIL wrap_valid n=%0d got=%0b", n, dout_valid); end
      if (n >= 2) begin
        checks++;
        if (dout !== 8'(n - 2)) begin failures++; $display("FAIL wrap_dout n=%0d got=%0d exp=%0d", n, dout, (n - 2) % 256); end
      end
      checks++;
      if (wr_addr !== 9'((n + 1) % 512)) begin failures++; $display("FAIL wrap_wr_addr n=%0d got=%0d exp=%0d", n, wr_addr, (n + 1) % 512); end
      checks++;
      if (fill !== 9'((n + 1 > 511) ? 511 : n + 1)) begin failures++; $display("FAIL wrap_fill n=%0d got=%0d", n, fill); end
    end
  endtask

  task automatic test_offset_increase();
    logic [7:0] held;
    step(1'b0, 1'b1, 8'h00, 9'd2);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'(k * 7 + 3), 9'd2);
    held = 8'(7 * 7 + 3);
    checks++; if (dout !== held) begin failures++; $display("FAIL inc_pre_dout got=%0d exp=%0d", dout, held); end
    step(1'b0, 1'b0, 8'hEE, 9'd20);
    checks++; if (dout !== held) begin failures++; $display("FAIL inc_idle_dout got=%0d exp=%0d", dout, held); end
    checks++; if (fill !== 9'd10) begin failures++; $display("FAIL inc_idle_fill got=%0d exp=10", fill); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL inc_idle_valid got=%0b exp=0", dout_valid); end
    for (int k = 10; k < 25; k++) begin
      step(1'b1, 1'b0, 8'(k * 7 + 3), 9'd20);
      checks++;
      if (dout_valid !== 1'(k >= 20)) begin failures++; $display("FAIL inc_valid k=%0d got=%0b exp=%0b", k, dout_valid, k >= 20); end
      if (k >= 20) begin
        checks++;
        if (dout !== 8'((k - 20) * 7 + 3)) begin failures++; $display("FAIL inc_dout k=%0d got=%0d exp=%0d", k, dout, 8'((k - 20) * 7 + 3)); end
      end
    end
  endtask

  task automatic test_clr_and_reset();
    step(1'b0, 1'b1, 8'h00, 9'd0);
    step(1'b1, 1'b0, 8'h11, 9'd0);
    step(1'b1, 1'b0, 8'h22, 9'd0);
    step(1'b1, 1'b1, 8'h99, 9'd0);
    checks++; if (wr_addr !== 9'd0) begin failures++; $display("FAIL clr_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (fill !== 9'd0) begin failures++; $display("FAIL clr_fill got=%0d exp=0", fill); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%0b exp=0", dout_valid); end
    checks++; if (dout !== 8'h22) begin failures++; $display("FAIL clr_dout_hold got=%0h exp=22", dout); end
    step(1'b1, 1'b0, 8'h44, 9'd0);
    checks++; if (dout !== 8'h44 || dout_valid !== 1'b1) begin failures++; $display("FAIL post_clr got=%0h/%0b exp=44/1", dout, dout_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL async_rst_dout got=%0h exp=0", dout); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%0b exp=0", dout_valid); end
    checks++; if (wr_addr !== 9'd0 || fill !== 9'd0) begin failures++; $display("FAIL async_rst_ptr got=%0d/%0d exp=0/0", wr_addr, fill); end
    step(1'b1, 1'b0, 8'h77, 9'd0);
    step(1'b1, 1'b0, 8'h78, 9'd0);
    checks++; if (wr_addr !== 9'd0 || fill !== 9'd0) begin failures++; $display("FAIL rst_held_accept got=%0d/%0d exp=0/0", wr_addr, fill); end
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h33, 9'd0);
    checks++; if (dout !== 8'h33 || dout_valid !== 1'b1) begin failures++; $display("FAIL rst_release got=%0h/%0b exp=33/1", dout, dout_valid); end
    checks++; if (wr_addr !== 9'd1 || fill !== 9'd1) begin failures++; $display("FAIL rst_release_ptr got=%0d/%0d exp=1/1", wr_addr, fill); end
  endtask

  task automatic test_random();
    logic [7:0] hist[$];
    int         cnt;
    bit         exp_valid;
    logic [7:0] exp_dout;
    bit         known;
    logic       e, c;
    logic [7:0] d;
    int         o;
    cnt = 0; exp_valid = 0; exp_dout = '0; known = 0; o = 1;
    step(1'b0, 1'b1, 8'h00, 9'd1);
    for (int t = 0; t < 3000; t++) begin
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 60) == 0);
      d = 8'($urandom);
      if ($urandom_range(0, 30) == 0)
        o = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 12));
      step(e, c, d, 9'(o));
      if (c) begin
        cnt = 0; hist.delete(); exp_valid = 0;
      end else if (e) begin
        exp_valid = (cnt >= o);
        hist.push_back(d);
        cnt++;
        if (exp_valid) begin
          exp_dout = hist[hist.size() - 1 - o];
          known = 1;
        end else begin
          known = 0;
        end
        if (hist.size() > 1024) void'(hist.pop_front());
      end else begin
        exp_valid = 0;
      end
      checks++;
      if (dout_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid t=%0d got=%0b exp=%0b", t, dout_valid, exp_valid); end
      checks++;
      if (wr_addr !== 9'(cnt % 512)) begin failures++; $display("FAIL rnd_wr_addr t=%0d got=%0d exp=%0d", t, wr_addr, cnt % 512); end
      checks++;
      if (fill !== 9'((cnt > 511) ? 511 : cnt)) begin failures++; $display("FAIL rnd_fill t=%0d got=%0d exp=%0d", t, fill, (cnt > 511) ? 511 : cnt); end
      if (known) begin
        checks++;
        if (dout !== exp_dout) begin failures++; $display("FAIL rnd_dout t=%0d got=%0h exp=%0h", t, dout, exp_dout); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_offset3();
    test_offset0();
    test_wrap();
    test_offset_increase();
    test_clr_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
